// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: captures bytes from the UART receiver into a first-word-fall-through
// FIFO. Each byte is stored with its framing flag. The block acknowledges every
// captured byte with a one-cycle data_read pulse, and it latches overrun and
// framing status for the host.
module rx_byte_fifo #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              data_ready,
   input  logic              overrun_error,
   input  logic              framing_error,
   output logic              data_read,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic              rd_fe,
   output logic              rd_valid,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              ovf_sticky,
   output logic              fe_sticky,
   input  logic              clr_status
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);

   logic [8:0]        mem_r [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic [ADDR_W:0]   count_nxt_s;
   logic              full_r;
   logic              valid_r;
   logic              data_read_r;
   logic              ovf_r;
   logic              fe_r;
   state_t            state_r;
   state_t            state_nxt_s;
   logic              space_s;
   logic              push_s;
   logic              pop_s;
   logic [8:0]        head_s;

   // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
   assign pop_s   = rd_en & valid_r;
   assign space_s = ~full_r | pop_s;

   // Capture FSM: IDLE pushes when the receiver has a byte and there is room.
   // ACK drives the acknowledge for one cycle and then returns to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      push_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (data_ready && space_s) begin
               push_s      = 1'b1;
               state_nxt_s = ACK;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACK: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Next occupancy: +1 on a push only, -1 on a pop only, otherwise unchanged.
   always_comb begin
      count_nxt_s = count_r;
      if (push_s && !pop_s) begin
         count_nxt_s = count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
         count_nxt_s = count_r - CNT_ONE;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // State, pointers, occupancy and the registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         full_r      <= 1'b0;
         valid_r     <= 1'b0;
         data_read_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         data_read_r <= (state_nxt_s == ACK);
         count_r     <= count_nxt_s;
         full_r      <= (count_nxt_s == CNT_MAX);
         valid_r     <= (count_nxt_s != CNT_ZERO);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Sticky status flags. A set condition in the same cycle as a clear takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_r <= 1'b0;
         fe_r  <= 1'b0;
      end else begin
         if (overrun_error) begin
            ovf_r <= 1'b1;
         end else if (clr_status) begin
            ovf_r <= 1'b0;
         end
         if (push_s && framing_error) begin
            fe_r <= 1'b1;
         end else if (clr_status) begin
            fe_r <= 1'b0;
         end
      end
   end

   // Storage array. Its contents do not matter out of reset, so it has no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {framing_error, rx_data};
      end
   end

   // Fall-through head. It is forced to zero while the FIFO is empty.
   always_comb begin
      head_s = 9'h000;
      if (valid_r) begin
         head_s = mem_r[rd_ptr_r];
      end else begin
         head_s = 9'h000;
      end
   end

   assign rd_data    = head_s[7:0];
   assign rd_fe      = head_s[8];
   assign rd_valid   = valid_r;
   assign full       = full_r;
   assign count      = count_r;
   assign data_read  = data_read_r;
   assign ovf_sticky = ovf_r;
   assign fe_sticky  = fe_r;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed testbench for rx_byte_fifo. It models the receiver handshake, and every
// expected value in it is worked out by hand.
module tb_rx_byte_fifo;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       data_ready;
   logic       overrun_error;
   logic       framing_error;
   logic       data_read;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_fe;
   logic       rd_valid;
   logic       full;
   logic [3:0] count;
   logic       ovf_sticky;
   logic       fe_sticky;
   logic       clr_status;

   int checks;
   int errors;

   rx_byte_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .data_ready    (data_ready),
      .overrun_error (overrun_error),
      .framing_error (framing_error),
      .data_read     (data_read),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_fe         (rd_fe),
      .rd_valid      (rd_valid),
      .full          (full),
      .count         (count),
      .ovf_sticky    (ovf_sticky),
      .fe_sticky     (fe_sticky),
      .clr_status    (clr_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Receiver model: present a byte, wait for the acknowledge (bounded), then drop data_ready.
   task automatic send_byte(input logic [7:0] b, input logic fe);
      int cyc;
      cyc = 0;
      rx_data       = b;
      framing_error = fe;
      data_ready    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         cyc = cyc + 1;
         if (data_read) break;
      end
      check("ack_latency", 16'(cyc), 16'd1);
      data_ready    = 1'b0;
      framing_error = 1'b0;
      tick();
      check("ack_one_cycle", {15'd0, data_read}, 16'd0);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      rx_data       = 8'h00;
      data_ready    = 1'b0;
      overrun_error = 1'b0;
      framing_error = 1'b0;
      rd_en         = 1'b0;
      clr_status    = 1'b0;
      tick();
      tick();
      check("rst_count", {12'd0, count}, 16'd0);
      check("rst_valid", {15'd0, rd_valid}, 16'd0);
      rst = 1'b0;
      tick();

      // 1: reset asserted in the middle of an ACK cycle
      rx_data    = 8'h55;
      data_ready = 1'b1;
      tick();
      check("pre_rst_ack", {15'd0, data_read}, 16'd1);
      rst = 1'b1;
      data_ready = 1'b0;
      #1;
      check("rst_async_dr", {15'd0, data_read}, 16'd0);
      check("rst_async_cnt", {12'd0, count}, 16'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_hold_dr", {15'd0, data_read}, 16'd0);
         check("rst_hold_valid", {15'd0, rd_valid}, 16'd0);
         check("rst_hold_full", {15'd0, full}, 16'd0);
         check("rst_hold_sticky", {14'd0, ovf_sticky, fe_sticky}, 16'd0);
         check("rst_hold_fe", {15'd0, rd_fe}, 16'd0);
      end
      rst = 1'b0;
      tick();

      // 2: single byte, then a pop
      send_byte(8'hA5, 1'b0);
      check("t2_valid", {15'd0, rd_valid}, 16'd1);
      check("t2_data", {8'd0, rd_data}, 16'h00A5);
      check("t2_fe", {15'd0, rd_fe}, 16'd0);
      check("t2_count", {12'd0, count}, 16'd1);
      pop_one();
      check("t2_count_pop", {12'd0, count}, 16'd0);
      check("t2_valid_pop", {15'd0, rd_valid}, 16'd0);

      // 3: fill, backpressure, push together with a pop while full, drain across the wrap
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
      check("t3_full", {15'd0, full}, 16'd1);
      check("t3_count8", {12'd0, count}, 16'd8);
      rx_data    = 8'h09;
      data_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_no_ack", {15'd0, data_read}, 16'd0);
         check("t3_hold_cnt", {12'd0, count}, 16'd8);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t3_ack_on_pop", {15'd0, data_read}, 16'd1);
      check("t3_count_same", {12'd0, count}, 16'd8);
      check("t3_full_same", {15'd0, full}, 16'd1);
      data_ready = 1'b0;
      tick();
      check("t3_ack_drop", {15'd0, data_read}, 16'd0);
      for (int i = 2; i <= 9; i++) begin
         check("t3_drain", {8'd0, rd_data}, 16'(i));
         pop_one();
      end
      check("t3_empty", {12'd0, count}, 16'd0);

      // 4: framing flag stored with the byte, sticky flags, set wins over clear
      send_byte(8'h3C, 1'b1);
      check("t4_data", {8'd0, rd_data}, 16'h003C);
      check("t4_rdfe", {15'd0, rd_fe}, 16'd1);
      check("t4_fes", {15'd0, fe_sticky}, 16'd1);
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      check("t4_fes_clr", {15'd0, fe_sticky}, 16'd0);
      check("t4_rdfe_keep", {15'd0, rd_fe}, 16'd1);
      overrun_error = 1'b1;
      clr_status    = 1'b1;
      tick();
      overrun_error = 1'b0;
      check("t4_ovf_setwins", {15'd0, ovf_sticky}, 16'd1);
      tick();
      clr_status = 1'b0;
      check("t4_ovf_clr", {15'd0, ovf_sticky}, 16'd0);
      pop_one();

      // 5: pop requests while empty are ignored
      rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_cnt", {12'd0, count}, 16'd0);
         check("t5_valid", {15'd0, rd_valid}, 16'd0);
      end
      rd_en = 1'b0;
      send_byte(8'h77, 1'b0);
      check("t5_data", {8'd0, rd_data}, 16'h0077);
      check("t5_cnt1", {12'd0, count}, 16'd1);
      pop_one();

      // 6: pop and push on the same edge when one entry is held
      send_byte(8'h11, 1'b0);
      check("t6_head", {8'd0, rd_data}, 16'h0011);
      rx_data    = 8'h22;
      data_ready = 1'b1;
      rd_en      = 1'b1;
      tick();
      rd_en      = 1'b0;
      data_ready = 1'b0;
      check("t6_ack", {15'd0, data_read}, 16'd1);
      check("t6_cnt", {12'd0, count}, 16'd1);
      check("t6_data", {8'd0, rd_data}, 16'h0022);
      tick();
      check("t6_ack_drop", {15'd0, data_read}, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
